vmem_seq: RTL

VMEM_SEQ -- requirements
Module: vmem_seq

---
 rtl/vmem_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vmem_seq.sv
// Strided vector load/store sequencer: walks base + k*stride over up to LANES
// elements, issuing single-cycle RD or WR strobes on a simple memory port.
module vmem_seq #(
  parameter int LANES = 16,
  parameter int DW    = 16,
  parameter int AW    = 16
) (
  input  logic                   Clk1,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [AW-1:0]          base,
  input  logic [AW-1:0]          stride,
  input  logic [$clog2(LANES):0] len,
  input  logic [LANES*DW-1:0]    vec_in,
  output logic [LANES*DW-1:0]    vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          Addr,
  output logic                   RD,
  output logic                   WR,
  output logic [DW-1:0]          DataOut,
  input  logic [DW-1:0]          DataIn
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | issuing RD strobes, one element per cycle
  // DRAIN | last read data in flight, RD low
  // STORE | issuing WR strobes, one element per cycle
  // FIN   | done pulse; start is accepted here as in IDLE
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, FIN} state_t;

  localparam int LW = $clog2(LANES);
  localparam int CW = LW + 1;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, len_q, eff_len;
  logic [AW-1:0]  acc, acc_nxt, stride_q, addr_nxt;
  logic [DW-1:0]  dout_nxt;
  logic           rd_nxt, wr_nxt, busy_nxt, done_nxt, accept;
  logic [DW-1:0]  lane_q [LANES];
  logic [DW-1:0]  out_q  [LANES];
  logic           cap_valid;
  logic [LW-1:0]  cap_lane, rd_lane;

  assign accept  = ((state == IDLE) || (state == FIN)) && start;
  assign eff_len = (len > CW'(LANES)) ? CW'(LANES) : len;
  // cnt has already advanced past the element whose RD is on the bus
  assign rd_lane = LW'(cnt - CW'(1));

  for (genvar k = 0; k < LANES; k++) begin : g_out
    assign vec_out[k*DW +: DW] = out_q[k];
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      Addr      <= '0;
      DataOut   <= '0;
      cnt       <= '0;
      acc       <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      cap_valid <= 1'b0;
      cap_lane  <= '0;
      for (int k = 0; k < LANES; k++) begin
        out_q[k]  <= '0;
        lane_q[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      RD        <= rd_nxt;
      WR        <= wr_nxt;
      Addr      <= addr_nxt;
      DataOut   <= dout_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      // read data returns one cycle after the strobe, so the lane tag trails RD
      cap_valid <= RD;
      cap_lane  <= rd_lane;
      if (cap_valid) out_q[cap_lane] <= DataIn;
      if (accept) begin
        stride_q <= stride;
        len_q    <= eff_len;
        if (op) begin
          for (int k = 0; k < LANES; k++) lane_q[k] <= vec_in[k*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          if (len == '0) state_nxt = FIN;
          else           state_nxt = op ? STORE : LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD:    if (cnt == len_q) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      STORE:   if (cnt == len_q) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    addr_nxt = Addr;
    dout_nxt = DataOut;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    busy_nxt = (state_nxt == LOAD) || (state_nxt == DRAIN) || (state_nxt == STORE);
    done_nxt = (state_nxt == FIN);
    if (accept) begin
      cnt_nxt = '0;
      if (len != '0) begin
        rd_nxt   = ~op;
        wr_nxt   = op;
        addr_nxt = base;
        acc_nxt  = base + stride;
        cnt_nxt  = CW'(1);
        if (op) dout_nxt = vec_in[DW-1:0];
      end
    end else if (((state == LOAD) || (state == STORE)) && (cnt != len_q)) begin
      rd_nxt   = (state == LOAD);
      wr_nxt   = (state == STORE);
      addr_nxt = acc;
      acc_nxt  = acc + stride_q;
      cnt_nxt  = cnt + CW'(1);
      if (state == STORE) dout_nxt = lane_q[cnt[LW-1:0]];
    end
  end

endmodule
